// File: rtl/tensor_pkg.sv
// Shared types and constants for the tensor bitcast engine: command layout,
// completion status codes, FSM states and the element-size decode.
package tensor_pkg;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 32;
    localparam int DIM_W    = 10;
    localparam int NUM_DIMS = 4;
    localparam int ELEMS_W  = NUM_DIMS * DIM_W;
    localparam int BYTES_W  = ELEMS_W + 3;
    localparam int CNT_W    = ADDR_W + 1;
    localparam int CMD_W    = 113;

    // Declared MSB first so the packed struct lines up with cmd_tdata bit positions.
    typedef struct packed {
        logic [2:0]         out_size;
        logic [2:0]         in_size;
        logic [ADDR_W-1:0]  dstn_addr;
        logic [ADDR_W-1:0]  src_addr;
        logic [ELEMS_W-1:0] dstn_dim;
        logic [ELEMS_W-1:0] src_dim;
        logic [4:0]         sub_field;
    } bitcast_cmd_t;

    typedef enum logic [1:0] {
        OK          = 2'd0,
        FMT_ERR     = 2'd1,
        RANGE_ERR   = 2'd2,
        OVERLAP_ERR = 2'd3
    } bitcast_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_CHECK,
        S_COPY,
        S_DONE
    } fsm_state_e;

    // Bytes per element for a size code; 0 flags an unsupported code.
    function automatic logic [3:0] size_bytes(input logic [2:0] code);
        case (code)
            3'd0:    return 4'd1;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/tensor_elem_count.sv
// Element count of a 4-D tensor shape; a zero-sized dimension counts as 1.
module tensor_elem_count
    import tensor_pkg::*;
(
    input  logic [ELEMS_W-1:0] dims,
    output logic [ELEMS_W-1:0] elems
);

    function automatic logic [ELEMS_W-1:0] eff_dim(input logic [DIM_W-1:0] d);
        return (d == '0) ? ELEMS_W'(1) : ELEMS_W'(d);
    endfunction

    // Each factor is at most 1023, so the product always fits in ELEMS_W bits.
    assign elems = eff_dim(dims[0*DIM_W +: DIM_W])
                 * eff_dim(dims[1*DIM_W +: DIM_W])
                 * eff_dim(dims[2*DIM_W +: DIM_W])
                 * eff_dim(dims[3*DIM_W +: DIM_W]);

endmodule

// File: rtl/tensor_bitcast_engine.sv
// Validates a bitcast command's byte footprints and address ranges, then copies
// the source tensor word-by-word from the source to the destination scratchpad.
module tensor_bitcast_engine
    import tensor_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CMD_W-1:0]  cmd_tdata,
    input  logic              cmd_tvalid,
    output logic              cmd_tready,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [DATA_W-1:0] src_rd_data,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_wr_addr,
    output logic [DATA_W-1:0] dst_wr_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status
);

    localparam logic [BYTES_W-1:0] SPACE = BYTES_W'(2 ** ADDR_W);

    fsm_state_e        state_q,     state_d;
    bitcast_cmd_t      cmd_q,       cmd_d;
    logic [BYTES_W-1:0] src_bytes_q, src_bytes_d;
    logic [BYTES_W-1:0] dst_bytes_q, dst_bytes_d;
    logic [BYTES_W-1:0] words_q,     words_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    bitcast_status_e   status_q,    status_d;

    logic [ELEMS_W-1:0] src_elems;
    logic [ELEMS_W-1:0] dst_elems;
    logic [BYTES_W-1:0] src_ext;
    logic [BYTES_W-1:0] dst_ext;
    logic               fmt_err;
    logic               range_err;
    logic               overlap_err;
    logic               last_beat;

    tensor_elem_count u_src_count (
        .dims  (cmd_q.src_dim),
        .elems (src_elems)
    );

    tensor_elem_count u_dst_count (
        .dims  (cmd_q.dstn_dim),
        .elems (dst_elems)
    );

    assign src_ext = BYTES_W'(cmd_q.src_addr);
    assign dst_ext = BYTES_W'(cmd_q.dstn_addr);

    assign fmt_err     = (size_bytes(cmd_q.in_size) == 4'd0)
                      || (size_bytes(cmd_q.out_size) == 4'd0)
                      || (src_bytes_q != dst_bytes_q);
    // Remaining room is measured without wrap-around past the top of the scratchpad.
    assign range_err   = (words_q > (SPACE - src_ext)) || (words_q > (SPACE - dst_ext));
    // Only a destination strictly inside the source window is clobbered by an ascending copy.
    assign overlap_err = (dst_ext > src_ext) && (dst_ext < (src_ext + words_q));
    assign last_beat   = (BYTES_W'(cnt_q) == words_q);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cmd_d       = cmd_q;
        src_bytes_d = src_bytes_q;
        dst_bytes_d = dst_bytes_q;
        words_d     = words_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        cmd_tready  = 1'b0;
        src_rd_en   = 1'b0;
        src_rd_addr = '0;
        dst_wr_en   = 1'b0;
        dst_wr_addr = '0;
        dst_wr_data = '0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_tready = 1'b1;
                if (cmd_tvalid) begin
                    cmd_d    = bitcast_cmd_t'(cmd_tdata);
                    status_d = OK;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                // Invalid size codes still produce a shift here; CHECK rejects them.
                src_bytes_d = BYTES_W'(src_elems) << cmd_q.in_size[1:0];
                dst_bytes_d = BYTES_W'(dst_elems) << cmd_q.out_size[1:0];
                words_d     = (src_bytes_d + BYTES_W'(3)) >> 2;
                state_d     = S_CHECK;
            end
            S_CHECK: begin
                if (fmt_err) begin
                    status_d = FMT_ERR;
                    state_d  = S_DONE;
                end else if (range_err) begin
                    status_d = RANGE_ERR;
                    state_d  = S_DONE;
                end else if (overlap_err) begin
                    status_d = OVERLAP_ERR;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_COPY;
                end
            end
            S_COPY: begin
                // Read of word cnt overlaps the write of word cnt-1, whose data arrives this cycle.
                if (!last_beat) begin
                    src_rd_en   = 1'b1;
                    src_rd_addr = cmd_q.src_addr + cnt_q[ADDR_W-1:0];
                end
                if (cnt_q != '0) begin
                    dst_wr_en   = 1'b1;
                    dst_wr_addr = cmd_q.dstn_addr + cnt_q[ADDR_W-1:0] - ADDR_W'(1);
                    dst_wr_data = src_rd_data;
                end
                if (last_beat) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            src_bytes_q <= '0;
            dst_bytes_q <= '0;
            words_q     <= '0;
            cnt_q       <= '0;
            status_q    <= OK;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            src_bytes_q <= src_bytes_d;
            dst_bytes_q <= dst_bytes_d;
            words_q     <= words_d;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign status = status_q;

endmodule
